// File: rtl/sw_key_debounce_pkg.sv
// Shared constants and helpers for the DE2 switch/key input conditioner.
package input_cond_pkg;

    localparam int SW_W        = 18;
    localparam int KEY_W       = 4;
    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;

    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int COND_WIDTH_DEFAULT      = SW_W + KEY_W;

    // KEY bits sit above the switches and idle high on the board
    localparam logic [COND_WIDTH_DEFAULT-1:0] INIT_LEVEL_DE2 =
        {{KEY_W{1'b1}}, {SW_W{1'b0}}};

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

    function automatic int count_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sw_key_debounce_if.sv
// Raw input / conditioned output bundle between the pins and the datapath.
interface sw_key_debounce_if
    import input_cond_pkg::*;
#(
    parameter int WIDTH = COND_WIDTH_DEFAULT
) ();

    logic [WIDTH-1:0] iRAW;
    logic [WIDTH-1:0] oLEVEL;
    logic [WIDTH-1:0] oRISE;
    logic [WIDTH-1:0] oFALL;
    logic             oCHANGE;

    modport master (
        output iRAW,
        input  oLEVEL,
        input  oRISE,
        input  oFALL,
        input  oCHANGE
    );

    modport slave (
        input  iRAW,
        output oLEVEL,
        output oRISE,
        output oFALL,
        output oCHANGE
    );

endinterface

// File: rtl/sw_key_debounce_bit.sv
// One conditioned input: synchronizer chain, stability counter, level and strobes.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic INIT_VAL        = 1'b0
) (
    input  logic iCLOCK,
    input  logic iRESET,
    input  logic iRAW,
    output logic oLEVEL,
    output logic oRISE,
    output logic oFALL,
    output logic oEVENT_D
);

    localparam int               CNT_W    = count_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   sample_s;
    edge_e                  edge_s;

    // Synchronizer shift and stability counting against the accepted level
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], iRAW};
        sample_s = sync_q[SYNC_STAGES-1];
        cnt_d    = {CNT_W{1'b0}};
        level_d  = level_q;
        edge_s   = EDGE_NONE;
        if (sample_s == level_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            // enough consecutive disagreeing samples: accept the new level
            level_d = sample_s;
            cnt_d   = {CNT_W{1'b0}};
            edge_s  = sample_s ? EDGE_RISE : EDGE_FALL;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Strobe decode, registered alongside the level
    always_comb begin
        rise_d = 1'b0;
        fall_d = 1'b0;
        case (edge_s)
            EDGE_RISE: rise_d = 1'b1;
            EDGE_FALL: fall_d = 1'b1;
            EDGE_NONE: begin
                rise_d = 1'b0;
                fall_d = 1'b0;
            end
            default: begin
                rise_d = 1'b0;
                fall_d = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            sync_q  <= {SYNC_STAGES{INIT_VAL}};
            cnt_q   <= {CNT_W{1'b0}};
            level_q <= INIT_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign oLEVEL   = level_q;
    assign oRISE    = rise_q;
    assign oFALL    = fall_q;
    assign oEVENT_D = rise_d | fall_d;

endmodule

// File: rtl/sw_key_debounce_chk.sv
// Parameter legality and output-consistency checks for the conditioner.
module sw_key_debounce_chk #(
    parameter int WIDTH           = 22,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input logic             iCLOCK,
    input logic             iRESET,
    input logic [WIDTH-1:0] rise,
    input logic [WIDTH-1:0] fall,
    input logic             change
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("sw_key_debounce: SYNC_STAGES must be >= 2");
    end

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("sw_key_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    // A bit can only move one way per accepted change
    a_rise_fall_excl: assert property (@(posedge iCLOCK) disable iff (iRESET)
        (rise & fall) == {WIDTH{1'b0}});

    a_change_summary: assert property (@(posedge iCLOCK) disable iff (iRESET)
        change == (|(rise | fall)));

endmodule

// File: rtl/sw_key_debounce.sv
// SW/KEY conditioner: per-bit synchronize + debounce, with rise/fall strobes and a change flag.
module sw_key_debounce
    import input_cond_pkg::*;
#(
    parameter int               WIDTH           = COND_WIDTH_DEFAULT,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [WIDTH-1:0] INIT_LEVEL      = {WIDTH{1'b0}}
) (
    input logic               iCLOCK,
    input logic               iRESET,
    sw_key_debounce_if.slave  bus
);

    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] event_d_s;
    logic             change_q;
    logic             change_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INIT_VAL       (INIT_LEVEL[i])
        ) u_bit (
            .iCLOCK  (iCLOCK),
            .iRESET  (iRESET),
            .iRAW    (bus.iRAW[i]),
            .oLEVEL  (level_s[i]),
            .oRISE   (rise_s[i]),
            .oFALL   (fall_s[i]),
            .oEVENT_D(event_d_s[i])
        );
    end

    // Change flag computed from next-cycle strobes so it lands with them
    always_comb begin
        change_d = |event_d_s;
    end

    // Change flag register
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            change_q <= 1'b0;
        end else begin
            change_q <= change_d;
        end
    end

    assign bus.oLEVEL  = level_s;
    assign bus.oRISE   = rise_s;
    assign bus.oFALL   = fall_s;
    assign bus.oCHANGE = change_q;

    sw_key_debounce_chk #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chk (
        .iCLOCK(iCLOCK),
        .iRESET(iRESET),
        .rise  (rise_s),
        .fall  (fall_s),
        .change(change_q)
    );

endmodule

// File: tb/tb_sw_key_debounce.sv
// Bench for sw_key_debounce: directed scenarios plus random stimulus against a window-rule model.
module tb_sw_key_debounce;

    localparam int               W    = 4;
    localparam int               SS   = 2;
    localparam int               DC   = 4;
    localparam logic [W-1:0]     INIT = 4'b1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sw_key_debounce_if #(.WIDTH(W)) bus ();

    sw_key_debounce #(
        .WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .INIT_LEVEL(INIT)
    ) dut (
        .iCLOCK(clk),
        .iRESET(rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: raw history since reset release; a bit flips when the last DC
    // synchronized samples (each SS edges old) all disagree with its level.
    logic [W-1:0] hist[$];
    int           edge_k;
    logic [W-1:0] m_level, m_rise, m_fall;
    logic         m_change;

    task automatic model_reset();
        hist.delete();
        edge_k   = 0;
        m_level  = INIT;
        m_rise   = '0;
        m_fall   = '0;
        m_change = 1'b0;
    endtask

    function automatic logic s_at(int k, int b);
        logic [W-1:0] v;
        if (k - SS >= 1) v = hist[k-SS-1];
        else v = INIT;
        return v[b];
    endfunction

    task automatic step(input logic [W-1:0] raw);
        bit flip;
        bus.iRAW = raw;
        @(posedge clk);
        if (!rst) begin
            edge_k++;
            hist.push_back(raw);
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < W; b++) begin
                if (edge_k - DC + 1 >= 1) begin
                    flip = 1'b1;
                    for (int j = edge_k - DC + 1; j <= edge_k; j++)
                        if (s_at(j, b) == m_level[b]) flip = 1'b0;
                    if (flip) begin
                        if (m_level[b]) m_fall[b] = 1'b1;
                        else m_rise[b] = 1'b1;
                        m_level[b] = ~m_level[b];
                    end
                end
            end
            m_change = |(m_rise | m_fall);
        end
        #1;
    endtask

    task automatic do_reset(input logic [W-1:0] raw);
        rst = 1'b1;
        bus.iRAW = raw;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iRAW = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.oLEVEL !== INIT || bus.oRISE !== 4'b0000 || bus.oFALL !== 4'b0000 || bus.oCHANGE !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: level=%b rise=%b fall=%b chg=%b, required level=%b no strobes",
                     bus.oLEVEL, bus.oRISE, bus.oFALL, bus.oCHANGE, INIT);
        end
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 20; k++) begin
            step(4'b1000);
            checks++;
            if (bus.oLEVEL !== INIT || bus.oRISE !== 4'b0000 || bus.oFALL !== 4'b0000 || bus.oCHANGE !== 1'b0) begin
                errors++;
                $display("FAIL reset_release edge %0d: level=%b rise=%b fall=%b chg=%b, required level=%b no strobes",
                         k, bus.oLEVEL, bus.oRISE, bus.oFALL, bus.oCHANGE, INIT);
            end
        end
    endtask

    task automatic test_single_rise();
        logic [W-1:0] exp_rise, exp_level;
        do_reset(4'b1000);
        for (int k = 1; k <= 10; k++) begin
            step(4'b1001);
            exp_rise  = (k == 6) ? 4'b0001 : 4'b0000;
            exp_level = (k >= 6) ? 4'b1001 : 4'b1000;
            checks++;
            if (bus.oRISE !== exp_rise || bus.oLEVEL !== exp_level || bus.oCHANGE !== (k == 6)
                || bus.oFALL !== 4'b0000) begin
                errors++;
                $display("FAIL single_rise edge %0d: rise=%b level=%b chg=%b fall=%b, required rise=%b level=%b chg=%0d",
                         k, bus.oRISE, bus.oLEVEL, bus.oCHANGE, bus.oFALL, exp_rise, exp_level, (k == 6));
            end
        end
    endtask

    task automatic test_short_pulse();
        do_reset(4'b1000);
        for (int k = 1; k <= 15; k++) begin
            step((k <= 3) ? 4'b1010 : 4'b1000);
            checks++;
            if (bus.oLEVEL !== 4'b1000 || bus.oRISE !== 4'b0000 || bus.oCHANGE !== 1'b0) begin
                errors++;
                $display("FAIL short_pulse edge %0d: level=%b rise=%b chg=%b, required level=1000 no strobes",
                         k, bus.oLEVEL, bus.oRISE, bus.oCHANGE);
            end
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        int rise_edge = -1;
        logic b2;
        do_reset(4'b1000);
        for (int k = 1; k <= 20; k++) begin
            b2 = (k <= 8) ? ~(((k - 1) / 2) % 2 == 1) : 1'b1;
            step({1'b1, b2, 2'b00});
            if (bus.oRISE[2]) begin
                rises++;
                rise_edge = k;
            end
        end
        checks++;
        if (rises != 1 || rise_edge != 14 || bus.oLEVEL !== 4'b1100) begin
            errors++;
            $display("FAIL bounce: %0d rises at edge %0d level=%b, required 1 rise at edge 14 level=1100",
                     rises, rise_edge, bus.oLEVEL);
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] er, ef;
        do_reset(4'b1001);
        for (int k = 1; k <= 8; k++) step(4'b1001);
        for (int k = 9; k <= 18; k++) begin
            step(4'b0101);
            er = (k == 14) ? 4'b0100 : 4'b0000;
            ef = (k == 14) ? 4'b1000 : 4'b0000;
            checks++;
            if (bus.oRISE !== er || bus.oFALL !== ef || bus.oCHANGE !== (k == 14)) begin
                errors++;
                $display("FAIL simultaneous edge %0d: rise=%b fall=%b chg=%b, required rise=%b fall=%b chg=%0d",
                         k, bus.oRISE, bus.oFALL, bus.oCHANGE, er, ef, (k == 14));
            end
        end
        checks++;
        if (bus.oLEVEL !== 4'b0101) begin
            errors++;
            $display("FAIL simultaneous_level: level=%b, required 0101", bus.oLEVEL);
        end
    endtask

    task automatic test_reset_midcount();
        logic [W-1:0] er;
        do_reset(4'b1000);
        for (int k = 1; k <= 4; k++) begin
            step(4'b1010);
            checks++;
            if (bus.oRISE !== 4'b0000 || bus.oLEVEL !== 4'b1000) begin
                errors++;
                $display("FAIL midcount_pre edge %0d: rise=%b level=%b, required rise=0000 level=1000",
                         k, bus.oRISE, bus.oLEVEL);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.oLEVEL !== INIT || bus.oCHANGE !== 1'b0) begin
            errors++;
            $display("FAIL midcount_async: level=%b chg=%b, required level=%b chg=0",
                     bus.oLEVEL, bus.oCHANGE, INIT);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 9; k++) begin
            step(4'b1010);
            er = (k == 6) ? 4'b0010 : 4'b0000;
            checks++;
            if (bus.oRISE !== er || bus.oRISE !== m_rise || bus.oLEVEL !== m_level) begin
                errors++;
                $display("FAIL midcount_post edge %0d: rise=%b level=%b, required rise=%b level=%b",
                         k, bus.oRISE, bus.oLEVEL, er, m_level);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] raw;
        do_reset(INIT);
        raw = INIT;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_reset();
            end
            if ($urandom_range(0, 4) == 0)
                raw = raw ^ (4'b0001 << $urandom_range(0, 3));
            step(raw);
            checks++;
            if (bus.oLEVEL !== m_level || bus.oRISE !== m_rise || bus.oFALL !== m_fall
                || bus.oCHANGE !== m_change) begin
                errors++;
                $display("FAIL random cycle %0d: level=%b rise=%b fall=%b chg=%b, required %b %b %b %b",
                         n, bus.oLEVEL, bus.oRISE, bus.oFALL, bus.oCHANGE,
                         m_level, m_rise, m_fall, m_change);
            end
        end
    endtask

    initial begin
        bus.iRAW = INIT;
        model_reset();
        test_reset();
        test_single_rise();
        test_short_pulse();
        test_bounce();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_key_debounce.md
Name: sw_key_debounce

Overview:
Input conditioner that sits directly upstream of the operand-consuming datapath on the DE2 board, between the raw SW/KEY pins and adder_4bit. It replaces the bare two-flop switch/key buffering with a multi-stage synchronizer and a per-bit debounce filter. It presents clean stable levels plus one-cycle rise/fall strobes. Downstream logic takes operands from oLEVEL and uses strobes as commands, e.g. a KEY press to latch operands or to reset.

Parameters:
WIDTH, 22, number of conditioned inputs (18 SW + 4 KEY when used at top level)
SYNC_STAGES, 2, synchronizer flop depth; must be >= 2
DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a new level (10 ms at 50 MHz); must be >= 1
INIT_LEVEL, '0 (WIDTH bits), reset value of synchronizer and oLEVEL; set KEY bits to 1 (DE2 keys idle high)

Ports:
iCLOCK  in  1  system clock (CLOCK_50 domain)
iRESET  in  1  asynchronous, active-high reset
iRAW  in  WIDTH  asynchronous raw switch/key inputs
oLEVEL  out  WIDTH  debounced stable level
oRISE  out  WIDTH  one-cycle strobe, bit accepted 0->1
oFALL  out  WIDTH  one-cycle strobe, bit accepted 1->0
oCHANGE  out  1  OR-reduction of (oRISE | oFALL), registered in the same cycle as the strobes

Behaviour:
- Reset (async assert, sync release, active-high): sync chain = INIT_LEVEL, oLEVEL = INIT_LEVEL, all counters = 0, oRISE = oFALL = 0, oCHANGE = 0.
- First cycle after reset release generates no strobes, regardless of iRAW.
- Synchronizer: iRAW enters stage 0 each edge. Stage SYNC_STAGES-1 is the filtered sample s.
- Per bit, each edge:
  - if s == oLEVEL: counter <= 0.
  - if s != oLEVEL and counter < DEBOUNCE_CYCLES-1: counter++.
  - if s != oLEVEL and counter == DEBOUNCE_CYCLES-1: oLEVEL <= s, counter <= 0; oRISE or oFALL high for exactly this one cycle, registered alongside oLEVEL.
- Counter width = $clog2(DEBOUNCE_CYCLES) (min 1). The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Latency: iRAW steady and set up before edge 1 gives oLEVEL/strobe update on edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Any glitch shorter than DEBOUNCE_CYCLES samples at s clears the counter. No output change results.
- DEBOUNCE_CYCLES == 1: oLEVEL follows s with one cycle delay.
- Bits are fully independent. Simultaneous rises/falls on different bits strobe in the same cycle.
- Reset mid-count discards partial counts. After release, the full latency applies again.
- Elaboration assertion fails if SYNC_STAGES < 2 or DEBOUNCE_CYCLES < 1.

Decomposition:
- Package input_cond_pkg:
  - constants SW_W=18, KEY_W=4, CLK_HZ=50_000_000, DEBOUNCE_MS=10
  - derived localparam DEBOUNCE_CYCLES_DEFAULT
- Sub-module debounce_bit: one bit of synchronizer, counter and level/strobe logic, same iCLOCK/iRESET. sw_key_debounce instantiates it WIDTH times in a generate loop and forms oCHANGE.

Test Plan (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT_LEVEL=4'b1000):
- iRESET=1 with iRAW=4'hF, then release with iRAW=4'b1000 -> oLEVEL=4'b1000 throughout, no strobes for 20 cycles.
- iRAW[0] 0->1 before edge 1, held -> oLEVEL[0]=1 and oRISE[0]=1 on edge 6 only; oCHANGE=1 on edge 6 only.
- iRAW[1] high for 3 cycles then low -> oLEVEL[1] stays 0, oRISE/oCHANGE never assert.
- iRAW[2] bounces 1,0,1,0,1 (2 cycles each) then holds 1 -> exactly one oRISE[2] pulse, 6 edges after the final transition.
- Simultaneous iRAW[2] 0->1 and iRAW[3] 1->0, held -> same cycle oRISE=4'b0100, oFALL=4'b1000, oCHANGE=1, oLEVEL=4'b0101 (bit0 still 1).
- iRAW[1] 0->1; assert iRESET after 4 edges; release; hold -> no strobe before reset, rise occurs a full 6 edges after release.
